cpu_seq_ctrl: RTL
=================

// Module: cpu_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS core. Orders fetch, execute and memory phases on the shared Avalon-style port.
//  Drives the PC write-enable and branch strobe. Detects halt (PC reaches HALT_ADDR) and reports it on 'active'.
//  Sits between the PC, instruction register, register file and the memory bus; holds no datapath state itself.
// PARAMETERS
//  HALT_ADDR    32'h00000000  fetch address that stops execution
//  STALL_CNT_W  32            width of the stall counter (CPU_STALL_CNT_EN only)
// PORTS
//  clk            in   1   clock; all state changes on posedge
//  reset          in   1   synchronous, active-high; level-sensitive, may be held for many cycles
//  pc_val         in   32  current PC output
//  waitrequest    in   1   memory not ready; current request must be held
//  instr_is_load  in   1   decoded IR: load instruction
//  instr_is_store in   1   decoded IR: store instruction
//  instr_is_branch in  1   decoded IR: taken branch/jump (target already on PC input)
//  instr_wb       in   1   decoded IR: non-memory instruction writes a register
//  mem_read       out  1   bus read request
//  mem_write      out  1   bus write request
//  addr_sel       out  1   0 = PC drives bus address, 1 = ALU result drives it
//  ir_wen         out  1   latch readdata into the instruction register
//  pc_wen         out  1   PC write-enable (one-cycle pulse per instruction)
//  b_instr        out  1   branch strobe to the PC; only with pc_wen
//  reg_wen        out  1   register-file write-enable
//  active         out  1   high while executing; low in reset and after halt
//  stall_cycles   out  STALL_CNT_W  waitrequest stall count (CPU_STALL_CNT_EN only)
// BEHAVIOUR
//  - States: IDLE, FETCH, EXEC, MEM, HALT. A posedge with reset high forces IDLE.
//  - While reset is high, all outputs are 0 combinationally; this includes active and any in-flight request.
//  - IDLE: on the first posedge with reset low, go to FETCH. The PC then holds the reset vector. active=1 from FETCH onward.
//  - FETCH: if pc_val==HALT_ADDR, go to HALT with no bus request. Otherwise mem_read=1, addr_sel=0.
//    While waitrequest=1, stay in FETCH. On waitrequest=0, ir_wen=1 in the same cycle, then go to EXEC.
//  - EXEC: if load or store, go to MEM with no enables.
//    Otherwise pc_wen=1, b_instr=instr_is_branch, reg_wen=instr_wb, then go to FETCH.
//  - MEM: addr_sel=1; mem_read=instr_is_load, mem_write=instr_is_store. The request is held stable while waitrequest=1.
//    On waitrequest=0: pc_wen=1, reg_wen=instr_is_load, then go to FETCH. Branches never reach MEM.
//  - HALT: absorbing state; active=0, all enables 0. Only reset leaves it.
//  - Latency: 2 cycles per ALU/branch instruction, 3 per load/store, plus 1 cycle per waitrequest stall cycle.
//  - Invariants: mem_read and mem_write are never both 1.
//    pc_wen, ir_wen and reg_wen are single-cycle pulses. b_instr=1 implies pc_wen=1.
//  - Reset mid-FETCH or mid-MEM: the request drops in the reset cycle and the instruction is abandoned; no enables fire.
//  - instr_is_load and instr_is_store both high: treated as load.
// CONFIGURATION
//  CPU_STALL_CNT_EN defined:
//    stall_cycles port exists. It increments for each cycle with active=1, a request asserted and waitrequest=1.
//    It saturates at all-ones and clears on reset.
//  CPU_STALL_CNT_EN undefined: the port and counter are absent. The FSM is identical.
// STRUCTURE
//  cpu_ctrl_pkg holds:
//    state enum (IDLE/FETCH/EXEC/MEM/HALT);
//    addr_sel constants ADDR_PC=1'b0, ADDR_ALU=1'b1;
//    default HALT_ADDR.
//  Optional sub-module cpu_stall_counter holds the saturating counter, instantiated under CPU_STALL_CNT_EN. The FSM stays in this module.
// TESTING
//  1. Reset held 3 cycles, then released with pc_val=32'hBFC00000, waitrequest=0 ->
//     IDLE, FETCH, ir_wen pulse, EXEC; active rises on the FETCH cycle.
//  2. ALU instruction with instr_wb=1 -> EXEC cycle has pc_wen=1, reg_wen=1, b_instr=0; back to FETCH 2 cycles after fetch start.
//  3. Load with waitrequest high 4 cycles in MEM -> mem_read, addr_sel=1 held for 5 cycles.
//     pc_wen and reg_wen pulse once on the release cycle; stall_cycles +=4 if enabled.
//  4. Taken branch -> b_instr=1 together with pc_wen=1 in EXEC; no bus request in EXEC.
//  5. pc_val=32'h0 at FETCH -> HALT, active=0, no mem_read. Stays in HALT for 10 cycles; reset restarts from IDLE.
//  6. Reset asserted during MEM with waitrequest=1 -> mem_write drops in that cycle and no pc_wen fires; next state IDLE.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer of the MIPS core.
//   state_t           : sequencer states (IDLE, FETCH, EXEC, MEM, HALT)
//   ADDR_PC/ADDR_ALU  : encodings of the bus address select
//   DEFAULT_HALT_ADDR : fetch address that stops execution unless overridden
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_0000;

endpackage

// File: rtl/cpu_stall_counter.sv
// Saturating counter of bus stall cycles.
// Ports:
//   clk   in  clock, posedge
//   reset in  synchronous active-high clear
//   inc   in  count this cycle
//   count out current count, sticks at all-ones
module cpu_stall_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer for the MIPS core. Orders fetch, execute and memory
// phases on the shared Avalon-style port, drives PC write-enable and branch
// strobe, and reports halt (fetch from HALT_ADDR) on 'active'.
// Optional feature macro: CPU_STALL_CNT_EN adds the stall_cycles port and a
// saturating count of cycles spent with a request held off by waitrequest.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   pc_val                      current PC
//   waitrequest                 memory not ready, hold the request
//   instr_is_load/store/branch  decoded instruction class
//   instr_wb                    non-memory instruction writes a register
//   mem_read, mem_write         bus requests
//   addr_sel                    ADDR_PC or ADDR_ALU drives the bus address
//   ir_wen, pc_wen, reg_wen     single-cycle write-enables
//   b_instr                     branch strobe, only together with pc_wen
//   active                      high while executing
//   stall_cycles                stall count (CPU_STALL_CNT_EN only)
module cpu_seq_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = DEFAULT_HALT_ADDR
`ifdef CPU_STALL_CNT_EN
  , parameter int STALL_CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_val,
  input  logic        waitrequest,
  input  logic        instr_is_load,
  input  logic        instr_is_store,
  input  logic        instr_is_branch,
  input  logic        instr_wb,
  output logic        mem_read,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        ir_wen,
  output logic        pc_wen,
  output logic        b_instr,
  output logic        reg_wen,
  output logic        active
`ifdef CPU_STALL_CNT_EN
  , output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  state_t state, next_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs are decoded from the state and then forced to zero while reset
  // is high, so an in-flight request drops in the very cycle reset arrives.
  always_comb begin
    next_state = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = ADDR_PC;
    ir_wen     = 1'b0;
    pc_wen     = 1'b0;
    b_instr    = 1'b0;
    reg_wen    = 1'b0;
    active     = 1'b0;

    case (state)
      ST_IDLE: begin
        next_state = ST_FETCH;
      end
      ST_FETCH: begin
        active = 1'b1;
        if (pc_val == HALT_ADDR) begin
          next_state = ST_HALT;
        end else begin
          mem_read = 1'b1;
          addr_sel = ADDR_PC;
          if (!waitrequest) begin
            ir_wen     = 1'b1;
            next_state = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        active = 1'b1;
        if (instr_is_load || instr_is_store) begin
          next_state = ST_MEM;
        end else begin
          pc_wen     = 1'b1;
          b_instr    = instr_is_branch;
          reg_wen    = instr_wb;
          next_state = ST_FETCH;
        end
      end
      ST_MEM: begin
        active   = 1'b1;
        addr_sel = ADDR_ALU;
        // A load wins when both class bits are set, keeping read and write exclusive.
        mem_read  = instr_is_load;
        mem_write = instr_is_store && !instr_is_load;
        if (!waitrequest) begin
          pc_wen     = 1'b1;
          reg_wen    = instr_is_load;
          next_state = ST_FETCH;
        end
      end
      ST_HALT: begin
        next_state = ST_HALT;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    if (reset) begin
      next_state = ST_IDLE;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      addr_sel   = ADDR_PC;
      ir_wen     = 1'b0;
      pc_wen     = 1'b0;
      b_instr    = 1'b0;
      reg_wen    = 1'b0;
      active     = 1'b0;
    end
  end

`ifdef CPU_STALL_CNT_EN
  logic stall_inc;

  // Outputs are already zero in reset, so the increment is naturally gated.
  assign stall_inc = active && (mem_read || mem_write) && waitrequest;

  cpu_stall_counter #(
    .W(STALL_CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );
`endif

endmodule
